// File: rtl/exception_arbiter.sv
// MEM-stage exception arbiter: picks the highest-priority exception cause for CP0,
// flushes the pipeline and holds a redirect PC until the fetch stage accepts it.
module exception_arbiter #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0] EXC_NONE   = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic        mem_stall_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] mem_data_addr_i,
  input  logic        exc_if_adel_i,
  input  logic        exc_ri_i,
  input  logic        exc_ov_i,
  input  logic        exc_trap_i,
  input  logic        exc_sys_i,
  input  logic        exc_bp_i,
  input  logic        exc_adel_i,
  input  logic        exc_ades_i,
  input  logic        eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  input  logic        if_redirect_ack_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic        newpc_valid_o
);

  typedef enum logic {IDLE, REDIRECT} state_e;

  state_e      state_q, state_d;
  logic        int_q, int_d;
  logic [31:0] newpc_q, newpc_d;
  logic        newpc_valid_q, newpc_valid_d;

  logic [31:0] status_eff, cause_eff, epc_eff;
  logic        commit;
  logic [31:0] exc_type;
  logic [31:0] bad_addr;
  logic        flush;
  logic        unused_cp0_bits;

  // mtc0 in writeback must be visible here before CP0 itself has latched it
  always_comb begin
    status_eff = cp0_status_i;
    cause_eff  = cp0_cause_i;
    epc_eff    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        5'd12:   status_eff = wb_cp0_wdata_i;
        5'd13:   cause_eff[9:8] = wb_cp0_wdata_i[9:8];
        5'd14:   epc_eff = wb_cp0_wdata_i;
        default: ;
      endcase
    end
  end

  assign int_d = status_eff[0] & ~status_eff[1] & (|(cause_eff[15:8] & status_eff[15:8]));

  assign unused_cp0_bits = ^{status_eff[31:16], status_eff[7:2],
                             cause_eff[31:16], cause_eff[7:0]};

  assign commit = mem_valid_i & ~mem_stall_i & (state_q == IDLE) & ~rst;

  always_comb begin
    exc_type = EXC_NONE;
    bad_addr = 32'h0;
    if (commit) begin
      if (int_q)              exc_type = 32'h0;
      else if (exc_if_adel_i) begin
        exc_type = 32'h4;
        bad_addr = mem_pc_i;
      end
      else if (exc_ri_i)      exc_type = 32'ha;
      else if (exc_ov_i)      exc_type = 32'hc;
      else if (exc_trap_i)    exc_type = 32'hd;
      else if (exc_sys_i)     exc_type = 32'h8;
      else if (exc_bp_i)      exc_type = 32'h9;
      else if (exc_adel_i) begin
        exc_type = 32'h4;
        bad_addr = mem_data_addr_i;
      end
      else if (exc_ades_i) begin
        exc_type = 32'h5;
        bad_addr = mem_data_addr_i;
      end
      else if (eret_i)        exc_type = 32'he;
    end
  end

  assign flush = commit & (exc_type != EXC_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      int_q         <= 1'b0;
      newpc_q       <= 32'h0;
      newpc_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      int_q         <= int_d;
      newpc_q       <= newpc_d;
      newpc_valid_q <= newpc_valid_d;
    end
  end

  // Ack only counts once REDIRECT is already the current state
  always_comb begin
    state_d       = state_q;
    newpc_d       = newpc_q;
    newpc_valid_d = newpc_valid_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d       = REDIRECT;
          newpc_d       = (exc_type == 32'he) ? epc_eff : EXC_VECTOR;
          newpc_valid_d = 1'b1;
        end
      end
      REDIRECT: begin
        if (if_redirect_ack_i) begin
          state_d       = IDLE;
          newpc_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    excepttype_o        = exc_type;
    bad_addr_o          = bad_addr;
    flush_o             = flush;
    current_inst_addr_o = mem_pc_i;
    is_in_delayslot_o   = mem_in_delayslot_i;
    newpc_o             = newpc_q;
    newpc_valid_o       = newpc_valid_q;
  end

endmodule

// File: tb/tb_exception_arbiter.sv
// Directed-vector bench for exception_arbiter with hand-computed expected values.
module tb_exception_arbiter;

  localparam logic [31:0] NONE = 32'hFFFFFFFF;
  localparam logic [31:0] VEC  = 32'hBFC00380;

  localparam logic [8:0] F_IFADEL = 9'h100;
  localparam logic [8:0] F_RI     = 9'h080;
  localparam logic [8:0] F_OV     = 9'h040;
  localparam logic [8:0] F_TRAP   = 9'h020;
  localparam logic [8:0] F_SYS    = 9'h010;
  localparam logic [8:0] F_BP     = 9'h008;
  localparam logic [8:0] F_ADEL   = 9'h004;
  localparam logic [8:0] F_ADES   = 9'h002;
  localparam logic [8:0] F_ERET   = 9'h001;

  logic        clk = 1'b0;
  logic        rst;
  logic        memValid, memStall, memDs;
  logic [31:0] memPc, memAddr;
  logic [8:0]  flags;
  logic [31:0] cp0Status, cp0Cause, cp0Epc;
  logic        wbWe;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic        ack;

  logic [31:0] excType, curAddr, badAddr, newPc;
  logic        inDs, flush, newPcValid;

  int vecCount = 0;
  int errCount = 0;

  always #5 clk = ~clk;

  exception_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .mem_valid_i         (memValid),
    .mem_stall_i         (memStall),
    .mem_pc_i            (memPc),
    .mem_in_delayslot_i  (memDs),
    .mem_data_addr_i     (memAddr),
    .exc_if_adel_i       (flags[8]),
    .exc_ri_i            (flags[7]),
    .exc_ov_i            (flags[6]),
    .exc_trap_i          (flags[5]),
    .exc_sys_i           (flags[4]),
    .exc_bp_i            (flags[3]),
    .exc_adel_i          (flags[2]),
    .exc_ades_i          (flags[1]),
    .eret_i              (flags[0]),
    .cp0_status_i        (cp0Status),
    .cp0_cause_i         (cp0Cause),
    .cp0_epc_i           (cp0Epc),
    .wb_cp0_we_i         (wbWe),
    .wb_cp0_waddr_i      (wbAddr),
    .wb_cp0_wdata_i      (wbData),
    .if_redirect_ack_i   (ack),
    .excepttype_o        (excType),
    .current_inst_addr_o (curAddr),
    .is_in_delayslot_o   (inDs),
    .bad_addr_o          (badAddr),
    .flush_o             (flush),
    .newpc_o             (newPc),
    .newpc_valid_o       (newPcValid)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives the MEM-stage inputs and lets combinational outputs settle before checks
  task automatic applyStimulus(input logic [8:0] f, input logic [31:0] pc,
                               input logic [31:0] addr, input logic valid, input logic stall);
    flags    = f;
    memPc    = pc;
    memAddr  = addr;
    memValid = valid;
    memStall = stall;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves REDIRECT by acking for one cycle
  task automatic ackOnce();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  logic [8:0]  tblFlags [5];
  logic [31:0] tblExc   [5];
  logic [31:0] tblBad   [5];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; memDs = 1'b0; ack = 1'b0;
    cp0Status = 32'h0; cp0Cause = 32'h0; cp0Epc = 32'h0;
    wbWe = 1'b0; wbAddr = 5'd0; wbData = 32'h0;
    applyStimulus(9'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick(); tick();

    // Reset holds combinational outputs quiet even with an exception present
    applyStimulus(F_OV, 32'hBFC00000, 32'h0, 1'b1, 1'b0);
    checkOutput("rst_exc", excType, NONE);
    checkOutput("rst_flush", {31'h0, flush}, 32'h0);
    checkOutput("rst_bad", badAddr, 32'h0);
    checkOutput("rst_nvalid", {31'h0, newPcValid}, 32'h0);
    checkOutput("rst_newpc", newPc, 32'h0);
    tick();
    rst = 1'b0;

    // ri beats ov; delay-slot and PC passthrough
    memDs = 1'b1;
    applyStimulus(F_OV | F_RI, 32'hBFC00100, 32'h0, 1'b1, 1'b0);
    checkOutput("t1_exc", excType, 32'ha);
    checkOutput("t1_flush", {31'h0, flush}, 32'h1);
    checkOutput("t1_pc", curAddr, 32'hBFC00100);
    checkOutput("t1_ds", {31'h0, inDs}, 32'h1);
    checkOutput("t1_bad", badAddr, 32'h0);
    tick();
    applyStimulus(F_OV | F_RI, 32'hBFC00100, 32'h0, 1'b1, 1'b0);
    checkOutput("t1_flush2", {31'h0, flush}, 32'h0);
    checkOutput("t1_exc2", excType, NONE);
    checkOutput("t1_newpc", newPc, VEC);
    checkOutput("t1_nvalid", {31'h0, newPcValid}, 32'h1);
    tick();
    checkOutput("t1_hold_newpc", newPc, VEC);
    checkOutput("t1_hold_nvalid", {31'h0, newPcValid}, 32'h1);
    ackOnce();
    memDs = 1'b0;
    applyStimulus(9'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("t1_ack_nvalid", {31'h0, newPcValid}, 32'h0);

    // Ack in the entry cycle is not honoured
    ack = 1'b1;
    applyStimulus(F_BP, 32'h80000010, 32'h0, 1'b1, 1'b0);
    checkOutput("ackentry_exc", excType, 32'h9);
    tick();
    applyStimulus(9'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("ackentry_nvalid", {31'h0, newPcValid}, 32'h1);
    tick();
    ack = 1'b0;
    checkOutput("ackentry_release", {31'h0, newPcValid}, 32'h0);

    // Ack while IDLE is ignored
    ackOnce();
    checkOutput("idle_ack_nvalid", {31'h0, newPcValid}, 32'h0);

    // Interrupt: registered, so only visible one cycle later
    cp0Status = 32'h00000401; cp0Cause = 32'h00000400;
    applyStimulus(9'h0, 32'h80001000, 32'h0, 1'b1, 1'b0);
    checkOutput("int_first", excType, NONE);
    tick();
    applyStimulus(9'h0, 32'h80001004, 32'h0, 1'b1, 1'b0);
    checkOutput("int_exc", excType, 32'h0);
    checkOutput("int_flush", {31'h0, flush}, 32'h1);
    tick();
    cp0Status = 32'h00000403;
    applyStimulus(9'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("int_newpc", newPc, VEC);
    ackOnce();
    applyStimulus(9'h0, 32'h80001008, 32'h0, 1'b1, 1'b0);
    checkOutput("int_exl", excType, NONE);
    tick();
    checkOutput("int_exl2", excType, NONE);
    checkOutput("int_exl2_flush", {31'h0, flush}, 32'h0);

    // Cause[9:8] bypass from an mtc0 in writeback
    cp0Status = 32'h00000201; cp0Cause = 32'h0;
    wbWe = 1'b1; wbAddr = 5'd13; wbData = 32'h00000300;
    applyStimulus(9'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    wbWe = 1'b0;
    applyStimulus(9'h0, 32'h80001100, 32'h0, 1'b1, 1'b0);
    checkOutput("byp_exc", excType, 32'h0);
    tick();
    cp0Status = 32'h0;
    ackOnce();

    // Stalled MEM never commits; release cycle reports the adel
    for (int i = 0; i < 3; i++) begin
      applyStimulus(F_ADEL, 32'h80002000, 32'h80000003, 1'b1, 1'b1);
      checkOutput("stall_exc", excType, NONE);
      checkOutput("stall_flush", {31'h0, flush}, 32'h0);
      tick();
    end
    applyStimulus(F_ADEL, 32'h80002000, 32'h80000003, 1'b1, 1'b0);
    checkOutput("rel_exc", excType, 32'h4);
    checkOutput("rel_bad", badAddr, 32'h80000003);
    checkOutput("rel_flush", {31'h0, flush}, 32'h1);
    tick();
    applyStimulus(F_ADEL, 32'h80002000, 32'h80000003, 1'b1, 1'b0);
    checkOutput("rel2_exc", excType, NONE);
    checkOutput("rel2_bad", badAddr, 32'h0);
    ackOnce();

    // Fetch misalignment outranks data misalignment and reports the PC
    applyStimulus(F_IFADEL | F_ADEL | F_ADES, 32'hBFC00102, 32'h80000005, 1'b1, 1'b0);
    checkOutput("ifadel_exc", excType, 32'h4);
    checkOutput("ifadel_bad", badAddr, 32'hBFC00102);
    tick();
    ackOnce();

    tblFlags[0] = F_ADES;                 tblExc[0] = 32'h5; tblBad[0] = 32'h80000006;
    tblFlags[1] = F_TRAP | F_SYS | F_BP;  tblExc[1] = 32'hd; tblBad[1] = 32'h0;
    tblFlags[2] = F_SYS | F_BP;           tblExc[2] = 32'h8; tblBad[2] = 32'h0;
    tblFlags[3] = F_OV | F_TRAP;          tblExc[3] = 32'hc; tblBad[3] = 32'h0;
    tblFlags[4] = F_ERET | F_ADES;        tblExc[4] = 32'h5; tblBad[4] = 32'h80000006;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(tblFlags[i], 32'h80003000, 32'h80000006, 1'b1, 1'b0);
      checkOutput($sformatf("tbl%0d_exc", i), excType, tblExc[i]);
      checkOutput($sformatf("tbl%0d_bad", i), badAddr, tblBad[i]);
      tick();
      ackOnce();
    end

    // eret picks up EPC being written by mtc0 in the same cycle
    cp0Epc = 32'h0;
    wbWe = 1'b1; wbAddr = 5'd14; wbData = 32'hBFC00200;
    applyStimulus(F_ERET, 32'h80004000, 32'h0, 1'b1, 1'b0);
    checkOutput("eret_exc", excType, 32'he);
    checkOutput("eret_flush", {31'h0, flush}, 32'h1);
    tick();
    wbWe = 1'b0;
    applyStimulus(9'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("eret_newpc", newPc, 32'hBFC00200);
    checkOutput("eret_nvalid", {31'h0, newPcValid}, 32'h1);

    // syscall arriving in REDIRECT waits until after the ack
    applyStimulus(F_SYS, 32'h80005000, 32'h0, 1'b1, 1'b0);
    checkOutput("redir_exc", excType, NONE);
    checkOutput("redir_flush", {31'h0, flush}, 32'h0);
    tick();
    checkOutput("redir_exc2", excType, NONE);
    checkOutput("redir_hold", newPc, 32'hBFC00200);
    ackOnce();
    applyStimulus(F_SYS, 32'h80005000, 32'h0, 1'b1, 1'b0);
    checkOutput("sys_exc", excType, 32'h8);
    checkOutput("sys_flush", {31'h0, flush}, 32'h1);
    tick();
    checkOutput("sys_newpc", newPc, VEC);
    checkOutput("sys_nvalid", {31'h0, newPcValid}, 32'h1);

    // Reset from REDIRECT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(9'h0, 32'h80006000, 32'h0, 1'b1, 1'b0);
    checkOutput("rst2_nvalid", {31'h0, newPcValid}, 32'h0);
    checkOutput("rst2_newpc", newPc, 32'h0);
    checkOutput("rst2_exc", excType, NONE);
    applyStimulus(F_SYS, 32'h80006000, 32'h0, 1'b1, 1'b0);
    checkOutput("rst2_idle_exc", excType, 32'h8);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
